// File: rtl/eth_mii_tx.sv
// MII transmit engine: fetches a frame from a synchronous byte buffer and
// sends preamble, SFD, data, optional zero padding and CRC-32 FCS one nibble
// per clock, followed by a 24-cycle inter-frame gap.
//
// Handshake: start is a one-cycle request honoured only while the engine is
// idle (busy=0); the buffer is read with a one-cycle rd_en strobe and rd_data
// is taken exactly one cycle after each strobe, with no back-pressure.
module eth_mii_tx #(
  parameter int MAX_LEN = 1514,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       len,
  input  logic              pad_en,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [3:0]        txd,
  output logic              tx_en,
  output logic              tx_er,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_ABRT
  } state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] MIN_FRAME = 16'd60;

  // state_q describes what is on the MII pins this cycle
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] byte_q, byte_d;
  logic        nib_q, nib_d;
  logic [15:0] len_q, len_d;
  logic        pad_q, pad_d;

  logic [7:0]  data_q;
  logic [31:0] crc_q;

  logic              len_ok, abortable, capture, pad_byte;
  logic [31:0]       fcs_w;
  logic [15:0]       next_byte;
  logic [3:0]        txd_d;
  logic              tx_en_d, tx_er_d, busy_d, done_d, err_d, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign len_ok    = (len != 16'd0) && (len <= MAX_LEN_W);
  assign abortable = (state_q == S_PRE) || (state_q == S_SFD) || (state_q == S_DATA) ||
                     (state_q == S_PAD) || (state_q == S_FCS);
  assign dbg_state = state_q;

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      nib_q   <= 1'b0;
      len_q   <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      nib_q   <= nib_d;
      len_q   <= len_d;
      pad_q   <= pad_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    nib_d   = nib_q;
    len_d   = len_q;
    pad_d   = pad_q;
    case (state_q)
      S_IDLE: if (start && len_ok) begin
        state_d = S_PRE;
        cnt_d   = '0;
        len_d   = len;
        pad_d   = pad_en;
      end
      S_PRE: if (cnt_q == 5'd14) state_d = S_SFD;
             else cnt_d = cnt_q + 5'd1;
      S_SFD: begin
        state_d = S_DATA;
        byte_d  = '0;
        nib_d   = 1'b0;
      end
      S_DATA: if (!nib_q) nib_d = 1'b1;
      else begin
        nib_d  = 1'b0;
        byte_d = byte_q + 16'd1;
        if (byte_q == len_q - 16'd1) begin
          if (pad_q && (len_q < MIN_FRAME)) state_d = S_PAD;
          else begin
            state_d = S_FCS;
            cnt_d   = '0;
          end
        end
      end
      S_PAD: if (!nib_q) nib_d = 1'b1;
      else begin
        nib_d  = 1'b0;
        byte_d = byte_q + 16'd1;
        if (byte_q == MIN_FRAME - 16'd1) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: if (cnt_q == 5'd7) begin
        state_d = S_IFG;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 5'd1;
      S_IFG: if (cnt_q == 5'd23) state_d = S_IDLE;
             else cnt_d = cnt_q + 5'd1;
      S_ABRT: begin
        state_d = S_IFG;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abortable && abort) state_d = S_ABRT;
  end

  // Next values of the registered pins, derived from the upcoming state
  always_comb begin
    capture   = (state_d == S_DATA) && !nib_d;
    pad_byte  = (state_d == S_PAD) && !nib_d;
    fcs_w     = ~crc_q;
    next_byte = byte_d + 16'd1;
    txd_d     = 4'h0;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_IFG) && (cnt_d == 5'd23);
    err_d     = (state_q == S_IDLE) && start && !len_ok;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    case (state_d)
      S_PRE:  begin txd_d = 4'h5; tx_en_d = 1'b1; end
      S_SFD:  begin txd_d = 4'hD; tx_en_d = 1'b1; end
      S_DATA: begin txd_d = nib_d ? data_q[7:4] : rd_data[3:0]; tx_en_d = 1'b1; end
      S_PAD:  begin txd_d = 4'h0; tx_en_d = 1'b1; end
      S_FCS:  begin txd_d = fcs_w[{cnt_d[2:0], 2'b00} +: 4]; tx_en_d = 1'b1; end
      S_ABRT: begin txd_d = 4'h0; tx_en_d = 1'b1; tx_er_d = 1'b1; end
      default: ;
    endcase
    // Fetch each byte two cycles ahead of its low nibble on the wire
    if ((state_d == S_PRE) && (cnt_d == 5'd14)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
    end else if (capture && (byte_d < len_q - 16'd1)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = next_byte[ADDR_W-1:0];
    end
  end

  // Byte holding register and running CRC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      crc_q  <= 32'hFFFFFFFF;
    end else if ((state_q == S_IDLE) && (state_d == S_PRE)) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (capture) begin
      data_q <= rd_data;
      crc_q  <= crc_byte(crc_q, rd_data);
    end else if (pad_byte) begin
      data_q <= 8'h00;
      crc_q  <= crc_byte(crc_q, 8'h00);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd     <= 4'h0;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      txd     <= txd_d;
      tx_en   <= tx_en_d;
      tx_er   <= tx_er_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_eth_mii_tx.sv
// Self-checking bench for eth_mii_tx: expected MII nibbles are queued when a
// frame is requested and popped as the engine transmits them.
module tb_eth_mii_tx;

  localparam int MAX_LEN = 1514;
  localparam int ADDR_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       len = '0;
  logic              pad_en = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        rd_data = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        txd;
  logic              tx_en, tx_er, busy, done, err;
  logic [2:0]        dbg_state;

  logic [7:0] mem [0:2047];
  logic [3:0] exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int tx_cycles, er_cycles, rd_count, max_addr, done_count, err_count;
  int idle_bad, ifg_cnt, ifg_at_done;
  int push_cut, push_cnt;

  eth_mii_tx #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .pad_en(pad_en),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Buffer model: data is only meaningful the cycle after a strobe
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and activity monitor
  always @(negedge clk) begin
    if (tx_en && !tx_er) begin
      tx_cycles++;
      ifg_cnt = 0;
      if (exp_q.size() == 0) check("txd_extra_nibble", 32'd1, 32'd0);
      else check("txd", {28'd0, txd}, {28'd0, exp_q.pop_front()});
    end else if (tx_en && tx_er) begin
      tx_cycles++;
      er_cycles++;
      ifg_cnt = 0;
      if (txd != 4'h0) idle_bad++;
    end else begin
      if (txd != 4'h0) idle_bad++;
      if (tx_er) idle_bad++;
      if (busy) ifg_cnt++;
    end
    if (rd_en) begin
      rd_count++;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    if (done) begin
      done_count++;
      ifg_at_done = ifg_cnt;
    end
    if (err) err_count++;
  end

  task automatic push_nib(input logic [3:0] n);
    if (push_cut == 0 || push_cnt < push_cut) exp_q.push_back(n);
    push_cnt++;
  endtask

  task automatic build_expected(input int n, input bit pad, input int cut,
                                input bit force_fcs, input logic [31:0] fcs_val);
    int total;
    logic [31:0] c, fcs;
    logic [7:0] b;
    push_cut = cut;
    push_cnt = 0;
    for (int i = 0; i < 15; i++) push_nib(4'h5);
    push_nib(4'hD);
    total = (pad && n < 60) ? 60 : n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total; i++) begin
      b = (i < n) ? mem[i] : 8'h00;
      push_nib(b[3:0]);
      push_nib(b[7:4]);
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    fcs = force_fcs ? fcs_val : ~c;
    for (int k = 0; k < 8; k++) push_nib(fcs[4*k +: 4]);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input int n, input bit pad, input bit with_abort);
    @(posedge clk); #1;
    check("idle_before_start", {31'd0, busy}, 32'd0);
    check("done_single_cycle", {31'd0, done}, 32'd0);
    tx_cycles = 0; er_cycles = 0; rd_count = 0; max_addr = 0;
    done_count = 0; err_count = 0; idle_bad = 0; ifg_cnt = 0; ifg_at_done = 0;
    start = 1'b1; len = 16'(n); pad_en = pad; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("first_preamble_en", {31'd0, tx_en}, 32'd1);
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_until_done(input int budget, input int abort_at, input int start_at);
    bit got_done;
    got_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (abort_at > 0 && tx_cycles == abort_at) abort = 1'b1;
      if (start_at > 0 && c == start_at) begin
        start = 1'b1;
        len = 16'd5;
      end else start = 1'b0;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_frame(input string name, input int exp_tx, input int exp_rd, input int exp_er);
    check({name, "_tx_en_cycles"}, tx_cycles, exp_tx);
    check({name, "_rd_pulses"}, rd_count, exp_rd);
    check({name, "_tx_er_cycles"}, er_cycles, exp_er);
    check({name, "_nibbles_left"}, exp_q.size(), 0);
    check({name, "_ifg_len"}, ifg_at_done, 24);
    check({name, "_done_count"}, done_count, 1);
    check({name, "_err_count"}, err_count, 0);
    check({name, "_idle_pins"}, idle_bad, 0);
  endtask

  task automatic bad_start(input int n);
    @(posedge clk); #1;
    start = 1'b1; len = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_err_pulse", {31'd0, err}, 32'd1);
    check("bad_tx_en", {31'd0, tx_en}, 32'd0);
    check("bad_busy", {31'd0, busy}, 32'd0);
    check("bad_rd_en", {31'd0, rd_en}, 32'd0);
    @(posedge clk); #1;
    check("bad_err_one_cycle", {31'd0, err}, 32'd0);
    check("bad_busy_after", {31'd0, busy}, 32'd0);
  endtask

  int rn, rp, rtot;

  initial begin
    // Reset
    fill_mem();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {28'd0, txd}, 32'd0);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_tx_er", {31'd0, tx_er}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_rd_addr", {21'd0, rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "123456789" with the well-known check value
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    build_expected(9, 1'b0, 0, 1'b1, 32'hCBF43926);
    send(9, 1'b0, 1'b0);
    run_until_done(200, 0, 0);
    end_frame("crc_check", 42, 9, 0);

    // Short frame padded to 60 bytes, sent back to back
    fill_mem();
    build_expected(14, 1'b1, 0, 1'b0, 32'd0);
    send(14, 1'b1, 1'b0);
    run_until_done(400, 0, 0);
    end_frame("pad14", 144, 14, 0);

    // Rejected lengths
    bad_start(0);
    bad_start(MAX_LEN + 1);

    // Largest frame with an ignored mid-frame start
    fill_mem();
    build_expected(MAX_LEN, 1'b0, 0, 1'b0, 32'd0);
    send(MAX_LEN, 1'b0, 1'b0);
    run_until_done(4000, 0, 1000);
    end_frame("max_len", 16 + 2 * MAX_LEN + 8, MAX_LEN, 0);
    check("max_rd_addr", max_addr, MAX_LEN - 1);

    // Abort while byte 5 low nibble is on the wire; abort held through IFG
    fill_mem();
    build_expected(20, 1'b0, 27, 1'b0, 32'd0);
    send(20, 1'b0, 1'b0);
    run_until_done(300, 27, 0);
    end_frame("abort", 28, 7, 1);

    // Start and abort together in IDLE: the frame proceeds normally
    fill_mem();
    build_expected(25, 1'b1, 0, 1'b0, 32'd0);
    send(25, 1'b1, 1'b1);
    run_until_done(400, 0, 0);
    end_frame("after_abort", 144, 25, 0);

    // Reset during FCS
    fill_mem();
    build_expected(30, 1'b0, 0, 1'b0, 32'd0);
    send(30, 1'b0, 1'b0);
    for (int c = 0; c < 300 && tx_cycles < 79; c++) begin
      @(negedge clk); #1;
    end
    check("rst_reached_fcs", tx_cycles, 79);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", {31'd0, tx_en}, 32'd0);
    check("midrst_txd", {28'd0, txd}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rd_en", {31'd0, rd_en}, 32'd0);
    check("midrst_fcs_left", exp_q.size(), 5);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_state", {29'd0, dbg_state}, 32'd0);
    check("postrst_no_done", done_count, 0);
    check("postrst_no_err", err_count, 0);

    // Random frame after reset
    fill_mem();
    rn = $urandom_range(1, 80);
    rp = $urandom_range(0, 1);
    rtot = (rp == 1 && rn < 60) ? 60 : rn;
    build_expected(rn, rp[0], 0, 1'b0, 32'd0);
    send(rn, rp[0], 1'b0);
    run_until_done(500, 0, 0);
    end_frame("random", 16 + 2 * rtot + 8, rn, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
